omsp_hmac_driver: RTL

- Host-side initiator for the 16-bit HMAC wrapper.
- Fetches a message buffer from a word-wide memory port and streams it into the wrapper using its start/continue handshake.
- Optionally reads back the MAC word by word and writes it to a destination buffer.
- Performs the wrapper's one-time INIT request on the first command after reset. Sits between the Sancus crypto control logic and the wrapper instance.

---
 rtl/omsp_hmac_driver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/omsp_hmac_driver.sv
// Fetches a message buffer, streams it into the 16-bit HMAC wrapper and optionally writes the MAC back.
// Latency: one wrapper request per message word plus MAC_WORDS read-back requests; busy from the cycle after cmd_start.
// Backpressure: every wrapper request waits for hmac_busy to drop; memory writes are always accepted.
module omsp_hmac_driver #(
    parameter int MAC_WORDS = 8,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic              cmd_final,
    input  logic [7:0]        cmd_hdr,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [15:0]       src_len,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    output logic              hmac_start_continue,
    output logic              hmac_data_available,
    output logic              hmac_data_is_long,
    output logic [15:0]       hmac_data_in,
    input  logic [15:0]       hmac_data_out,
    input  logic              hmac_busy,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(MAC_WORDS + 1);

    typedef enum logic [3:0] {
        IDLE, INIT_REQ, INIT_WAIT, RD_REQ, RD_DATA, IN_REQ, IN_WAIT,
        OUT_REQ, OUT_WAIT, WR, DONE
    } state_t;

    state_t             state, state_nxt;
    logic               armed;
    logic               init_done;
    logic [7:0]         hdr_q;
    logic               fin_q;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  dst_q;
    logic [15:0]        bytes_left;
    logic [CNT_W-1:0]   word_cnt;
    logic [15:0]        rdata_q;
    logic [15:0]        out_q;

    logic               in_wait;
    logic               wait_done;
    logic               is_long;
    logic [15:0]        step;
    logic [15:0]        bytes_after;

    // armed is clear in a wait state's entry cycle, so busy is never sampled there
    assign in_wait     = (state == INIT_WAIT) || (state == IN_WAIT) || (state == OUT_WAIT);
    assign wait_done   = in_wait && armed && !hmac_busy;
    assign is_long     = (bytes_left >= 16'd2);
    assign step        = is_long ? 16'd2 : 16'd1;
    assign bytes_after = bytes_left - step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= in_wait && (state_nxt == state);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_done  <= 1'b0;
            hdr_q      <= '0;
            fin_q      <= 1'b0;
            ptr        <= '0;
            dst_q      <= '0;
            bytes_left <= '0;
            word_cnt   <= '0;
            rdata_q    <= '0;
            out_q      <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_start) begin
                    hdr_q      <= cmd_hdr;
                    fin_q      <= cmd_final;
                    ptr        <= src_addr;
                    dst_q      <= dst_addr;
                    bytes_left <= src_len;
                    word_cnt   <= '0;
                end
                INIT_WAIT: if (wait_done) init_done <= 1'b1;
                RD_DATA:   rdata_q <= mem_rdata;
                IN_WAIT: if (wait_done) begin
                    bytes_left <= bytes_after;
                    ptr        <= ptr + ADDR_W'(2);
                end
                OUT_WAIT: if (wait_done) out_q <= hmac_data_out;
                WR:        word_cnt <= word_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt           = state;
        mem_addr            = '0;
        mem_rd              = 1'b0;
        mem_wr              = 1'b0;
        mem_wdata           = '0;
        hmac_start_continue = 1'b0;
        hmac_data_available = 1'b0;
        hmac_data_is_long   = 1'b0;
        hmac_data_in        = '0;
        busy                = (state != IDLE) && (state != DONE);
        done                = (state == DONE);
        case (state)
            IDLE: if (cmd_start) begin
                if (!init_done)          state_nxt = INIT_REQ;
                else if (src_len != '0)  state_nxt = RD_REQ;
                else if (cmd_final)      state_nxt = OUT_REQ;
                else                     state_nxt = DONE;
            end
            INIT_REQ, INIT_WAIT: begin
                hmac_start_continue = (state == INIT_REQ);
                hmac_data_available = 1'b1;
                hmac_data_in        = {8'h00, hdr_q};
                if (state == INIT_REQ)        state_nxt = INIT_WAIT;
                else if (wait_done) begin
                    if (bytes_left != '0)     state_nxt = RD_REQ;
                    else if (fin_q)           state_nxt = OUT_REQ;
                    else                      state_nxt = DONE;
                end
            end
            RD_REQ: begin
                mem_rd    = 1'b1;
                mem_addr  = ptr;
                state_nxt = RD_DATA;
            end
            RD_DATA: state_nxt = IN_REQ;
            IN_REQ, IN_WAIT: begin
                hmac_start_continue = (state == IN_REQ);
                hmac_data_available = 1'b1;
                hmac_data_is_long   = is_long;
                hmac_data_in        = is_long ? {rdata_q[7:0], rdata_q[15:8]} : {8'h00, rdata_q[7:0]};
                if (state == IN_REQ)          state_nxt = IN_WAIT;
                else if (wait_done) begin
                    if (bytes_after != '0)    state_nxt = RD_REQ;
                    else if (fin_q)           state_nxt = OUT_REQ;
                    else                      state_nxt = DONE;
                end
            end
            OUT_REQ: begin
                hmac_start_continue = 1'b1;
                state_nxt           = OUT_WAIT;
            end
            OUT_WAIT: if (wait_done) state_nxt = WR;
            WR: begin
                mem_wr    = 1'b1;
                mem_addr  = dst_q + ADDR_W'({word_cnt, 1'b0});
                mem_wdata = {out_q[7:0], out_q[15:8]};
                state_nxt = (word_cnt == CNT_W'(MAC_WORDS - 1)) ? DONE : OUT_REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
